// File: rtl/stepper_phase_decoder.sv
// Stepper phase decoder: reconstructs step, direction, position and step
// period from the 4-bit full-step coil pattern, with homing, overtravel
// and skipped/illegal-phase detection. All outputs are registered.
module stepper_phase_decoder #(
  parameter int POS_WIDTH    = 16,
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  signal_in,
  input  logic [1:0]                  limit_switches,
  input  logic                        fault_clr,
  output logic                        step_pulse,
  output logic                        dir,
  output logic signed [POS_WIDTH-1:0] position,
  output logic [PERIOD_WIDTH-1:0]     step_period,
  output logic                        idle,
  output logic                        fault,
  output logic                        overtravel
);

  localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = {PERIOD_WIDTH{1'b1}};

  // True when exactly one coil is energised.
  function automatic logic is_onehot4(input logic [3:0] pat);
    logic ok;
    case (pat)
      4'b1000, 4'b0100, 4'b0010, 4'b0001: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Phase index in forward order 1000 -> 0100 -> 0010 -> 0001.
  function automatic logic [1:0] phase_idx(input logic [3:0] pat);
    logic [1:0] idx;
    case (pat)
      4'b1000: idx = 2'd0;
      4'b0100: idx = 2'd1;
      4'b0010: idx = 2'd2;
      4'b0001: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Saturating increment for the period counter.
  function automatic logic [PERIOD_WIDTH-1:0] sat_inc(input logic [PERIOD_WIDTH-1:0] v);
    logic [PERIOD_WIDTH-1:0] r;
    if (v == PERIOD_MAX) begin
      r = PERIOD_MAX;
    end else begin
      r = v + PERIOD_WIDTH'(1);
    end
    return r;
  endfunction

  // Synchroniser flops
  logic [3:0]              sig_s1_q, sig_s2_q;
  logic [1:0]              lim_s1_q, lim_s2_q;

  // Decoder state and registered outputs
  logic [1:0]              ref_idx_q,   ref_idx_d;
  logic                    ref_valid_q, ref_valid_d;
  logic [PERIOD_WIDTH-1:0] cnt_q,       cnt_d;
  logic                    step_q,      step_d;
  logic                    dir_q,       dir_d;
  logic [POS_WIDTH-1:0]    pos_q,       pos_d;
  logic [PERIOD_WIDTH-1:0] period_q,    period_d;
  logic                    idle_q,      idle_d;
  logic                    fault_q,     fault_d;
  logic                    ot_q,        ot_d;

  // Combinational decode intermediates
  logic                    home_s, far_s;
  logic                    onehot_s;
  logic [1:0]              idx_s, delta_s;
  logic                    fwd_s, rev_s, fault_set_s;

  // Two-stage synchronisers for the asynchronous coil and switch inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sig_s1_q <= 4'b0000;
      sig_s2_q <= 4'b0000;
      lim_s1_q <= 2'b00;
      lim_s2_q <= 2'b00;
    end else begin
      sig_s1_q <= signal_in;
      sig_s2_q <= sig_s1_q;
      lim_s1_q <= limit_switches;
      lim_s2_q <= lim_s1_q;
    end
  end

  // Decoder state and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ref_idx_q   <= 2'd0;
      ref_valid_q <= 1'b0;
      cnt_q       <= '0;
      step_q      <= 1'b0;
      dir_q       <= 1'b1;
      pos_q       <= '0;
      period_q    <= PERIOD_MAX;
      idle_q      <= 1'b1;
      fault_q     <= 1'b0;
      ot_q        <= 1'b0;
    end else begin
      ref_idx_q   <= ref_idx_d;
      ref_valid_q <= ref_valid_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      pos_q       <= pos_d;
      period_q    <= period_d;
      idle_q      <= idle_d;
      fault_q     <= fault_d;
      ot_q        <= ot_d;
    end
  end

  // Phase classification, position/period update and sticky flag logic.
  always_comb begin
    home_s      = lim_s2_q[0];
    far_s       = lim_s2_q[1];
    onehot_s    = is_onehot4(sig_s2_q);
    idx_s       = phase_idx(sig_s2_q);
    delta_s     = idx_s - ref_idx_q;
    fwd_s       = 1'b0;
    rev_s       = 1'b0;
    fault_set_s = 1'b0;
    ref_idx_d   = ref_idx_q;
    ref_valid_d = ref_valid_q;
    idle_d      = idle_q;

    if (sig_s2_q == 4'b0000) begin
      // Driver disabled: forget the reference phase.
      idle_d      = 1'b1;
      ref_valid_d = 1'b0;
    end else if (!onehot_s) begin
      // Multiple coils energised is never a legal full-step pattern.
      fault_set_s = 1'b1;
      ref_valid_d = 1'b0;
      idle_d      = 1'b0;
    end else begin
      ref_idx_d   = idx_s;
      ref_valid_d = 1'b1;
      idle_d      = 1'b0;
      if (ref_valid_q) begin
        case (delta_s)
          2'd1:    fwd_s       = 1'b1;
          2'd3:    rev_s       = 1'b1;
          2'd2:    fault_set_s = 1'b1;  // skipped phase: direction unknowable
          default: fwd_s       = 1'b0;  // same phase, hold
        endcase
      end else begin
        // First valid phase only establishes the reference.
        fwd_s = 1'b0;
      end
    end

    step_d = fwd_s | rev_s;

    if (fwd_s) begin
      dir_d = 1'b1;
    end else if (rev_s) begin
      dir_d = 1'b0;
    end else begin
      dir_d = dir_q;
    end

    // Home switch forces zero regardless of stepping.
    if (home_s) begin
      pos_d = '0;
    end else if (fwd_s) begin
      pos_d = pos_q + POS_WIDTH'(1);
    end else if (rev_s) begin
      pos_d = pos_q - POS_WIDTH'(1);
    end else begin
      pos_d = pos_q;
    end

    if (step_d) begin
      period_d = sat_inc(cnt_q);
      cnt_d    = '0;
    end else begin
      period_d = period_q;
      cnt_d    = sat_inc(cnt_q);
    end

    // Set beats clear when both happen in the same cycle.
    fault_d = fault_set_s | (fault_q & ~fault_clr);
    ot_d    = (fwd_s & far_s) | (ot_q & ~fault_clr);
  end

  assign step_pulse  = step_q;
  assign dir         = dir_q;
  assign position    = pos_q;
  assign step_period = period_q;
  assign idle        = idle_q;
  assign fault       = fault_q;
  assign overtravel  = ot_q;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Testbench for stepper_phase_decoder: directed coil sequences checked
// every cycle against a behavioural model, plus literal spot checks.
module tb_stepper_phase_decoder;

  localparam int PW = 16;
  localparam int TW = 12;  // short period counter so saturation is reachable
  localparam int TMAX = (1 << TW) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           signal_in;
  logic [1:0]           limit_switches;
  logic                 fault_clr;
  logic                 step_pulse;
  logic                 dir;
  logic signed [PW-1:0] position;
  logic [TW-1:0]        step_period;
  logic                 idle;
  logic                 fault;
  logic                 overtravel;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  bit started = 1'b0;

  stepper_phase_decoder #(.POS_WIDTH(PW), .PERIOD_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .signal_in(signal_in), .limit_switches(limit_switches),
    .fault_clr(fault_clr), .step_pulse(step_pulse), .dir(dir), .position(position),
    .step_period(step_period), .idle(idle), .fault(fault), .overtravel(overtravel)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [3:0]  h1, h2;        // input as seen 1 and 2 cycles late
  logic [1:0]  l1, l2;
  int          m_ref;
  bit          m_ref_ok;
  int          m_cnt;
  bit          m_step, m_dir, m_idle, m_fault, m_ot;
  logic [PW-1:0] m_pos;
  int          m_per;

  function automatic int find_idx(input logic [3:0] pat);
    logic [3:0] base;
    base = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      if ((base >> k) == pat) return k;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      h1 = 4'b0; h2 = 4'b0; l1 = 2'b0; l2 = 2'b0;
      m_ref = 0; m_ref_ok = 0; m_cnt = 0;
      m_step = 0; m_dir = 1; m_pos = '0; m_per = TMAX;
      m_idle = 1; m_fault = 0; m_ot = 0;
      started = 1'b1;
    end else begin
      int idx, d;
      bit fwd, rev, fset;
      fwd = 0; rev = 0; fset = 0;
      idx = find_idx(h2);
      if (h2 == 4'b0000) begin
        m_idle = 1; m_ref_ok = 0;
      end else if (idx < 0) begin
        fset = 1; m_ref_ok = 0; m_idle = 0;
      end else begin
        if (m_ref_ok) begin
          d = (idx - m_ref + 4) % 4;
          fwd  = (d == 1);
          rev  = (d == 3);
          fset = (d == 2);
        end
        m_ref = idx; m_ref_ok = 1; m_idle = 0;
      end
      m_step = fwd || rev;
      if (fwd) m_dir = 1;
      if (rev) m_dir = 0;
      if (l2[0]) m_pos = '0;
      else if (fwd) m_pos = m_pos + 1'b1;
      else if (rev) m_pos = m_pos - 1'b1;
      if (m_step) begin
        m_per = (m_cnt + 1 > TMAX) ? TMAX : m_cnt + 1;
        m_cnt = 0;
      end else begin
        m_cnt = (m_cnt + 1 > TMAX) ? TMAX : m_cnt + 1;
      end
      m_fault = fset || (m_fault && !fault_clr);
      m_ot    = (fwd && l2[1]) || (m_ot && !fault_clr);
      h2 = h1; h1 = signal_in;
      l2 = l1; l1 = limit_switches;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      total++;
      if (step_pulse !== m_step || dir !== m_dir || $unsigned(position) !== m_pos ||
          step_period !== TW'(m_per) || idle !== m_idle || fault !== m_fault ||
          overtravel !== m_ot) begin
        bad++;
        $display("FAIL model t=%0t: got step=%b dir=%b pos=%h per=%h idle=%b fault=%b ot=%b expected step=%b dir=%b pos=%h per=%h idle=%b fault=%b ot=%b",
                 $time, step_pulse, dir, position, step_period, idle, fault, overtravel,
                 m_step, m_dir, m_pos, TW'(m_per), m_idle, m_fault, m_ot);
      end
      if (step_pulse === 1'b1) pulses++;
    end
  end

  // ---------------- literal checks and stimulus ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic [3:0] pat, input int n);
    signal_in = pat;
    repeat (n) @(negedge clk);
  endtask

  // Apply a stepping pattern and verify the pulse lands exactly 3 cycles later.
  task automatic step_timed(input logic [3:0] pat, input int n);
    signal_in = pat;
    repeat (2) @(negedge clk);
    check("pulse_early", {31'd0, step_pulse}, 32'd0);
    @(negedge clk);
    check("pulse_at3", {31'd0, step_pulse}, 32'd1);
    repeat (n - 3) @(negedge clk);
  endtask

  initial begin
    int p0;
    logic [3:0] base;
    base = 4'b1000;
    rst = 1'b0; signal_in = 4'b0000; limit_switches = 2'b00; fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pos",    {16'd0, $unsigned(position)}, 32'd0);
    check("rst_idle",   {31'd0, idle}, 32'd1);
    check("rst_dir",    {31'd0, dir}, 32'd1);
    check("rst_period", {20'd0, step_period}, 32'hFFF);
    rst = 1'b1;

    // Forward sequence: resync then 4 steps, 10 cycles apart.
    p0 = pulses;
    hold(4'b1000, 10);
    check("resync_nopulse", pulses - p0, 32'd0);
    step_timed(4'b0100, 10);
    step_timed(4'b0010, 10);
    step_timed(4'b0001, 10);
    step_timed(4'b1000, 10);
    check("fwd_pulses", pulses - p0, 32'd4);
    check("fwd_pos",    {16'd0, $unsigned(position)}, 32'd4);
    check("fwd_dir",    {31'd0, dir}, 32'd1);
    check("fwd_period", {20'd0, step_period}, 32'd10);

    // Reverse steps, then a skipped phase.
    hold(4'b0001, 10); hold(4'b0010, 10); hold(4'b0100, 10);
    check("rev_pos", {16'd0, $unsigned(position)}, 32'd1);
    check("rev_dir", {31'd0, dir}, 32'd0);
    hold(4'b0001, 10);
    check("skip_fault", {31'd0, fault}, 32'd1);
    check("skip_pos",   {16'd0, $unsigned(position)}, 32'd1);
    fault_clr = 1'b1; @(negedge clk); fault_clr = 1'b0;
    check("clr_fault", {31'd0, fault}, 32'd0);

    // Illegal pattern, idle, resync.
    hold(4'b0110, 10);
    check("illegal_fault", {31'd0, fault}, 32'd1);
    hold(4'b0000, 10);
    check("idle_on", {31'd0, idle}, 32'd1);
    p0 = pulses;
    hold(4'b0010, 10);
    check("idle_off",   {31'd0, idle}, 32'd0);
    check("resync2",    pulses - p0, 32'd0);
    fault_clr = 1'b1; @(negedge clk); fault_clr = 1'b0;

    // Homing while stepping forward.
    limit_switches = 2'b01;
    hold(4'b0010, 5);
    p0 = pulses;
    hold(4'b0001, 5); hold(4'b1000, 5); hold(4'b0100, 5);
    check("home_pulses", pulses - p0, 32'd3);
    check("home_pos",    {16'd0, $unsigned(position)}, 32'd0);
    limit_switches = 2'b00;
    hold(4'b0100, 5);
    hold(4'b0010, 5);
    check("home_after", {16'd0, $unsigned(position)}, 32'd1);

    // Overtravel at far end.
    limit_switches = 2'b10;
    hold(4'b0010, 5);
    hold(4'b0001, 5);
    check("ot_set", {31'd0, overtravel}, 32'd1);
    hold(4'b0010, 5);
    check("ot_rev", {31'd0, overtravel}, 32'd1);
    check("ot_pos", {16'd0, $unsigned(position)}, 32'd1);
    signal_in = 4'b0001;
    repeat (2) @(negedge clk);
    fault_clr = 1'b1; @(negedge clk); fault_clr = 1'b0;
    repeat (4) @(negedge clk);
    check("ot_set_wins", {31'd0, overtravel}, 32'd1);
    limit_switches = 2'b00;
    fault_clr = 1'b1; @(negedge clk); fault_clr = 1'b0;
    check("ot_clear", {31'd0, overtravel}, 32'd0);

    // Reset mid-sequence: next pattern is only a resync.
    rst = 1'b0; repeat (2) @(negedge clk); rst = 1'b1;
    p0 = pulses;
    hold(4'b0001, 5);
    check("rst_resync", pulses - p0, 32'd0);
    check("rst_pos2",   {16'd0, $unsigned(position)}, 32'd0);

    // Position wrap: 32767 forward steps, one per cycle, then one more.
    for (int i = 1; i <= 32767; i++) begin
      signal_in = base >> ((3 + i) % 4);
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("pos_7fff", {16'd0, $unsigned(position)}, 32'h7FFF);
    hold(4'b0001, 5);
    check("pos_8000", {16'd0, $unsigned(position)}, 32'h8000);
    check("fast_dir", {31'd0, dir}, 32'd1);

    // Period saturation after a long pause.
    hold(4'b0001, 5000);
    hold(4'b1000, 5);
    check("period_sat", {20'd0, step_period}, 32'hFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stepper_phase_decoder.md
Name: stepper_phase_decoder

Overview:
- Reads the 4-bit full-step coil pattern produced by a stepper phase driver, or returned from the PmodSTEP header, and reconstructs motor motion.
- Outputs a step strobe, direction, signed position count, step period and fault flags.
- Uses the limit switches for homing and overtravel detection.
- Sits beside each motor channel in the claw top level as a closed-loop monitor of the driver output.

Parameters:
- POS_WIDTH, 16, width of the signed two's-complement position counter.
- PERIOD_WIDTH, 24, width of the step-period counter in clk cycles.

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous active-low reset; rst==0 at a rising clk edge resets
- signal_in  input  4  coil pattern from the step driver (asynchronous to clk)
- limit_switches  input  2  [0]=home switch, [1]=far-end switch, active-high, asynchronous
- fault_clr  input  1  synchronous, clears sticky fault and overtravel
- step_pulse  output  1  one-cycle strobe per decoded step
- dir  output  1  direction of the last decoded step; 1=forward
- position  output  POS_WIDTH  signed step count
- step_period  output  PERIOD_WIDTH  clk cycles between the last two steps
- idle  output  1  coil pattern is 4'b0000 (driver disabled)
- fault  output  1  sticky: skipped or illegal phase seen
- overtravel  output  1  sticky: forward step while far-end switch active

Behaviour:
- Synchronisation: signal_in and limit_switches each pass through 2 flops before any use. Decode logic sees only the synced values (p, home, far).
- Forward phase order: 4'b1000 → 4'b0100 → 4'b0010 → 4'b0001 → 4'b1000. Phase index 0..3 in that order.
- Internal state: ref_idx[1:0], ref_valid, cnt[PERIOD_WIDTH-1:0].
- Per-cycle decode of p, mutually exclusive, in priority order:
  - p==0000: idle<=1, ref_valid<=0, no step.
  - p not one-hot and nonzero: fault<=1, ref_valid<=0, idle<=0, no step.
  - p one-hot, ref_valid==0: ref_idx<=idx(p), ref_valid<=1, no step. This is a resync, not counted.
  - idx==ref_idx: hold.
  - idx==ref_idx+1 mod 4: step_pulse<=1, dir<=1, position<=position+1.
  - idx==ref_idx-1 mod 4: step_pulse<=1, dir<=0, position<=position-1.
  - idx==ref_idx+2 mod 4: fault<=1, ref_idx<=idx, no step, position unchanged.
  - All one-hot cases: ref_idx<=idx and idle<=0.
- Position: wraps modulo 2^POS_WIDTH, no saturation. 0x7FFF +1 → 0x8000 at the default width.
- Homing: while home==1, position<=0 every cycle. This overrides any increment or decrement; step_pulse and dir still update normally.
- Overtravel: a forward step while far==1 sets overtravel. A reverse step with far==1 is legal.
- Step period:
  - cnt increments every cycle and saturates at all-ones.
  - On step_pulse, step_period<=cnt+1 (saturating) and cnt<=0.
  - Consecutive steps N cycles apart (edge to edge) therefore give step_period==N.
- Flag clearing: fault_clr==1 clears fault and overtravel. If a set condition occurs in the same cycle, the set wins.
- Latency: a pattern change on signal_in produces step_pulse 3 clk cycles later (2 sync stages + 1 output register). All outputs are registered.
- Reset values (rst==0): step_pulse=0, dir=1, position=0, step_period=all-ones, idle=1, fault=0, overtravel=0, ref_valid=0, cnt=0, sync flops=0.
  - Reset mid-sequence discards the reference phase. The first pattern after reset is a resync and is not counted.
  - Reset takes priority over every other condition.

Test Plan:
- Reset release, then signal_in 1000,0100,0010,0001,1000, each held 10 cycles → first pattern resync with no pulse; 4 step_pulse, dir=1, position=4, step_period=10, step_pulse 3 cycles after each change.
- From position=4, sequence 0001,0010,0100 → 3 reverse pulses, dir=0, position=1; then 0100→0001 (skip) → fault=1, position unchanged; fault_clr → fault=0.
- Apply 0110, then 0000, then 0010 → fault=1 on 0110; idle=1 on 0000; 0010 taken as resync, no pulse, idle=0.
- Hold limit_switches[0]=1 during 3 forward steps → position stays 0, 3 step_pulse; release, 1 more step → position=1.
- limit_switches[1]=1 then 1 forward step → overtravel=1; 1 reverse step → no further change; fault_clr together with a forward step → overtravel stays 1.
- Preload position to 0x7FFF via 32767 forward steps, 1 more forward step → position=0x8000; no steps for 2^24 cycles, then a step → step_period=0xFFFFFF.
